// File: rtl/controle_exibicao_sequencia.sv
// Plays the stored colour sequence on the LEDs before each round:
// each entry is lit for T_ON cycles, then blanked for T_OFF cycles.
module controle_exibicao_sequencia #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 4,
    parameter int T_ON_FACIL    = 50,
    parameter int T_OFF_FACIL   = 25,
    parameter int T_ON_DIFICIL  = 20,
    parameter int T_OFF_DIFICIL = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic              dificuldade,
    input  logic [ADDR_W-1:0] nivel,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              liga_led,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int T_MAX_F = (T_ON_FACIL > T_OFF_FACIL) ? T_ON_FACIL : T_OFF_FACIL;
    localparam int T_MAX_D = (T_ON_DIFICIL > T_OFF_DIFICIL) ? T_ON_DIFICIL : T_OFF_DIFICIL;
    localparam int T_MAX   = (T_MAX_F > T_MAX_D) ? T_MAX_F : T_MAX_D;
    localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] ON_F_M1  = TW'(T_ON_FACIL - 1);
    localparam logic [TW-1:0] OFF_F_M1 = TW'(T_OFF_FACIL - 1);
    localparam logic [TW-1:0] ON_D_M1  = TW'(T_ON_DIFICIL - 1);
    localparam logic [TW-1:0] OFF_D_M1 = TW'(T_OFF_DIFICIL - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [DATA_W-1:0] leds_q, leds_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] nivel_q, nivel_d;
    logic              dif_q, dif_d;
    logic              liga_q, liga_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;
    logic [TW-1:0]     t_on_m1, t_off_m1;

    // Durations come from the latched mode so mid-run changes are ignored.
    assign t_on_m1  = dif_q ? ON_D_M1 : ON_F_M1;
    assign t_off_m1 = dif_q ? OFF_D_M1 : OFF_F_M1;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        timer_d    = timer_q;
        nivel_d    = nivel_q;
        dif_d      = dif_q;
        if (cancelar) begin
            estado_d = OCIOSO;
            leds_d   = '0;
            timer_d  = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        nivel_d    = nivel;
                        dif_d      = dificuldade;
                        endereco_d = '0;
                        estado_d   = CARREGA;
                    end
                end
                CARREGA: begin
                    leds_d   = dado_memoria;
                    timer_d  = '0;
                    estado_d = ACESO;
                end
                ACESO: begin
                    if (timer_q == t_on_m1) begin
                        timer_d  = '0;
                        leds_d   = '0;
                        estado_d = APAGADO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                APAGADO: begin
                    if (timer_q == t_off_m1) begin
                        timer_d = '0;
                        if (endereco_q == nivel_q) begin
                            estado_d = FIM;
                        end else begin
                            endereco_d = endereco_q + 1'b1;
                            estado_d   = CARREGA;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                    leds_d   = '0;
                    timer_d  = '0;
                end
            endcase
        end
        liga_d    = (estado_d == ACESO);
        ocupado_d = (estado_d != OCIOSO);
        pronto_d  = (estado_d == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            leds_q     <= '0;
            timer_q    <= '0;
            nivel_q    <= '0;
            dif_q      <= 1'b0;
            liga_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            timer_q    <= timer_d;
            nivel_q    <= nivel_d;
            dif_q      <= dif_d;
            liga_q     <= liga_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = leds_q;
    assign liga_led  = liga_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = {1'b0, estado_q};

endmodule
